// File: rtl/postfix_stack_evaluator.sv
// rtl/postfix_stack_evaluator.sv - Sequential RPN evaluator with operand stack and iterative divider
// Tokens are consumed one per handshake; a divide stalls the token stream for WIDTH cycles.
module postfix_stack_evaluator #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tok_valid,
  output logic             o_tok_ready,
  input  logic [1:0]       i_tok_type,
  input  logic [WIDTH-1:0] i_tok_data,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_data,
  output logic             o_overflow,
  output logic [3:0]       o_err
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {ST_ACCEPT, ST_DIV, ST_DONE} state_t;
  state_t r_state, w_state_next;

  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [DW-1:0]    r_depth;
  logic             r_overflow;
  logic [3:0]       r_err;
  logic [WIDTH-1:0] r_res_data;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic             r_neg, r_min_neg1;
  logic [CW-1:0]    r_cnt;

  logic                      w_tok_hs, w_res_hs, w_skip, w_lt2, w_full;
  logic                      w_div_start, w_div_last, w_alu_ovf, w_fits;
  logic [IW-1:0]             w_ip, w_ia, w_ib;
  logic signed [WIDTH-1:0]   w_a, w_b, w_alu;
  logic signed [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]          w_a_mag, w_b_mag, w_quo_nx, w_quo_fix;
  logic [WIDTH:0]            w_rem_sh, w_rem_sub;

  assign o_tok_ready = (r_state == ST_ACCEPT) && !rst;
  assign o_res_valid = (r_state == ST_DONE);
  assign o_res_data  = r_res_data;
  assign o_overflow  = r_overflow;
  assign o_err       = r_err;

  assign w_tok_hs = i_tok_valid && o_tok_ready;
  assign w_res_hs = o_res_valid && i_res_ready;
  assign w_skip   = |r_err;
  assign w_lt2    = r_depth < DW'(2);
  assign w_full   = r_depth == DW'(DEPTH);
  assign w_ip     = r_depth[IW-1:0];
  assign w_ib     = w_ip - IW'(1);
  assign w_ia     = w_ip - IW'(2);
  assign w_a      = $signed(r_stack[w_ia]);
  assign w_b      = $signed(r_stack[w_ib]);
  assign w_prod   = (2*WIDTH)'(w_a) * (2*WIDTH)'(w_b);

  always_comb begin
    w_alu     = w_a + w_b;
    w_alu_ovf = 1'b0;
    case (i_tok_data[1:0])
      2'b00: w_alu_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_alu[WIDTH-1] != w_a[WIDTH-1]);
      2'b01: begin
        w_alu     = w_a - w_b;
        w_alu_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_alu[WIDTH-1] != w_a[WIDTH-1]);
      end
      2'b10: begin
        w_alu     = w_prod[WIDTH-1:0];
        w_alu_ovf = w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}};
      end
      default: ;
    endcase
  end

  // Restoring division on magnitudes; the dividend shifts out of r_quo as quotient bits shift in.
  assign w_a_mag     = w_a[WIDTH-1] ? -w_a : w_a;
  assign w_b_mag     = w_b[WIDTH-1] ? -w_b : w_b;
  assign w_rem_sh    = {r_rem, r_quo[WIDTH-1]};
  assign w_rem_sub   = w_rem_sh - {1'b0, r_dvs};
  assign w_fits      = !w_rem_sub[WIDTH];
  assign w_quo_nx    = {r_quo[WIDTH-2:0], w_fits};
  assign w_quo_fix   = r_neg ? -w_quo_nx : w_quo_nx;
  assign w_div_last  = r_cnt == CW'(WIDTH - 1);
  assign w_div_start = w_tok_hs && (i_tok_type == 2'b01) && !w_skip && !w_lt2
                       && (i_tok_data[1:0] == 2'b11) && (w_b != '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_ACCEPT;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCEPT: begin
        if (w_tok_hs && i_tok_type == 2'b10) w_state_next = ST_DONE;
        else if (w_div_start)                w_state_next = ST_DIV;
      end
      ST_DIV:  if (w_div_last) w_state_next = ST_ACCEPT;
      ST_DONE: if (w_res_hs)   w_state_next = ST_ACCEPT;
      default: w_state_next = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_depth    <= '0;
      r_overflow <= 1'b0;
      r_err      <= '0;
      r_res_data <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        ST_ACCEPT: if (w_tok_hs && !(w_skip && i_tok_type != 2'b10)) begin
          case (i_tok_type)
            2'b00: begin
              if (w_full) r_err[1] <= 1'b1;
              else begin
                r_stack[w_ip] <= i_tok_data;
                r_depth       <= r_depth + DW'(1);
              end
            end
            2'b01: begin
              if (w_lt2) r_err[0] <= 1'b1;
              else if (i_tok_data[1:0] == 2'b11) begin
                if (w_b == '0) begin
                  r_err[2]      <= 1'b1;
                  r_stack[w_ia] <= '0;
                  r_depth       <= r_depth - DW'(1);
                end else begin
                  r_rem      <= '0;
                  r_quo      <= w_a_mag;
                  r_dvs      <= w_b_mag;
                  r_neg      <= w_a[WIDTH-1] ^ w_b[WIDTH-1];
                  r_min_neg1 <= (w_a == {1'b1, {(WIDTH-1){1'b0}}}) && (w_b == '1);
                  r_cnt      <= '0;
                end
              end else begin
                r_stack[w_ia] <= w_alu;
                r_depth       <= r_depth - DW'(1);
                r_overflow    <= r_overflow | w_alu_ovf;
              end
            end
            2'b10: begin
              if (!w_skip && r_depth == '0)     r_err[0] <= 1'b1;
              if (!w_skip && r_depth > DW'(1))  r_err[3] <= 1'b1;
              r_res_data <= (!w_skip && r_depth == DW'(1)) ? w_b : '0;
            end
            default: ;
          endcase
        end
        ST_DIV: begin
          r_rem <= w_fits ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + CW'(1);
          if (w_div_last) begin
            r_stack[w_ia] <= w_quo_fix;
            r_depth       <= r_depth - DW'(1);
            r_overflow    <= r_overflow | r_min_neg1;
          end
        end
        ST_DONE: if (w_res_hs) begin
          r_depth    <= '0;
          r_overflow <= 1'b0;
          r_err      <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_postfix_stack_evaluator.sv
// tb/tb_postfix_stack_evaluator.sv - Scoreboard bench for the RPN evaluator
// Three instances (32/16, 8/16, 32/4) share stimulus; sel picks which one is driven and observed.
module tb_postfix_stack_evaluator;
  localparam logic [1:0] T_OPND = 2'b00, T_OP = 2'b01, T_END = 2'b10;
  localparam logic [31:0] OP_ADD = 0, OP_SUB = 1, OP_MUL = 2, OP_DIV = 3;

  typedef struct packed {
    logic [31:0] d;
    logic        o;
    logic [3:0]  e;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, tv, rr;
  logic [1:0] tt;
  logic [31:0] td;
  int sel;
  int errors = 0;
  int checks = 0;
  int last_stall;
  exp_t sb[$];

  logic w32_rdy, w32_vld, w32_ovf, w8_rdy, w8_vld, w8_ovf, d4_rdy, d4_vld, d4_ovf;
  logic [31:0] w32_dat, d4_dat;
  logic [7:0] w8_dat;
  logic [3:0] w32_err, w8_err, d4_err;
  logic m_rdy, m_vld, m_ovf;
  logic [31:0] m_dat;
  logic [3:0] m_err;

  postfix_stack_evaluator #(.WIDTH(32), .DEPTH(16)) u_w32 (
    .clk(clk), .rst(rst), .i_tok_valid(tv && sel == 0), .o_tok_ready(w32_rdy),
    .i_tok_type(tt), .i_tok_data(td), .o_res_valid(w32_vld), .i_res_ready(rr && sel == 0),
    .o_res_data(w32_dat), .o_overflow(w32_ovf), .o_err(w32_err));
  postfix_stack_evaluator #(.WIDTH(8), .DEPTH(16)) u_w8 (
    .clk(clk), .rst(rst), .i_tok_valid(tv && sel == 1), .o_tok_ready(w8_rdy),
    .i_tok_type(tt), .i_tok_data(td[7:0]), .o_res_valid(w8_vld), .i_res_ready(rr && sel == 1),
    .o_res_data(w8_dat), .o_overflow(w8_ovf), .o_err(w8_err));
  postfix_stack_evaluator #(.WIDTH(32), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .i_tok_valid(tv && sel == 2), .o_tok_ready(d4_rdy),
    .i_tok_type(tt), .i_tok_data(td), .o_res_valid(d4_vld), .i_res_ready(rr && sel == 2),
    .o_res_data(d4_dat), .o_overflow(d4_ovf), .o_err(d4_err));

  always_comb begin
    m_rdy = w32_rdy; m_vld = w32_vld; m_dat = w32_dat; m_ovf = w32_ovf; m_err = w32_err;
    if (sel == 1) begin
      m_rdy = w8_rdy; m_vld = w8_vld; m_dat = {{24{w8_dat[7]}}, w8_dat}; m_ovf = w8_ovf; m_err = w8_err;
    end else if (sel == 2) begin
      m_rdy = d4_rdy; m_vld = d4_vld; m_dat = d4_dat; m_ovf = d4_ovf; m_err = d4_err;
    end
  end

  task automatic send(input logic [1:0] t, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    tv = 1'b1; tt = t; td = d;
    while (!m_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!m_rdy) begin
      checks++; errors++;
      $display("FAIL send_timeout: tok_ready=%0b after %0d cycles, required 1", m_rdy, n);
    end
    last_stall = n;
    @(posedge clk);
  endtask

  task automatic run_rpn(input string s, output int stalls);
    int i, j;
    string tok;
    logic [31:0] v;
    i = 0; stalls = 0;
    while (i < s.len()) begin
      if (s.getc(i) == " ") i++;
      else begin
        j = i;
        while (j < s.len() && s.getc(j) != " ") j++;
        tok = s.substr(i, j - 1);
        i = j;
        if (tok == "+")      send(T_OP, OP_ADD);
        else if (tok == "-") send(T_OP, OP_SUB);
        else if (tok == "*") send(T_OP, OP_MUL);
        else if (tok == "/") send(T_OP, OP_DIV);
        else begin
          if (tok.getc(0) == "-") v = -32'(tok.substr(1, tok.len() - 1).atoi());
          else                    v = 32'(tok.atoi());
          send(T_OPND, v);
        end
        stalls += last_stall;
      end
    end
  endtask

  task automatic get_result(output exp_t got, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    tv = 1'b0; rr = 1'b1;
    while (!m_vld && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = m_vld;
    got = {m_dat, m_ovf, m_err};
    @(posedge clk);
    @(negedge clk);
    rr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tv = 1'b0; rr = 1'b0; tt = '0; td = '0; sel = 0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      checks++;
      if ({m_rdy, m_vld, m_dat, m_ovf, m_err} !== 38'b0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: rdy=%0b vld=%0b data=%h ovf=%0b err=%b, required all 0",
                 s, m_rdy, m_vld, m_dat, m_ovf, m_err);
      end
    end
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      checks++;
      if (m_rdy !== 1'b1) begin
        errors++;
        $display("FAIL reset_release_ready[%0d]: got %0b required 1", s, m_rdy);
      end
    end
    sel = 0;
  endtask

  task automatic test_expr_521();
    int st;
    exp_t got, e;
    bit ok;
    sel = 0;
    sb.push_back({32'((5 + 6 + 20) * (3 + 4 + 10) - 3 * 2), 1'b0, 4'b0000});
    run_rpn("5 6 + 20 + 3 4 + 10 + * 3 2 * -", st);
    checks++;
    if (st !== 0) begin
      errors++;
      $display("FAIL expr_throughput: stall cycles=%0d required 0", st);
    end
    send(T_END, 0);
    get_result(got, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL expr_521: got data=%0d ovf=%0b err=%b valid=%0b, required data=%0d ovf=%0b err=%b",
               $signed(got.d), got.o, got.e, ok, $signed(e.d), e.o, e.e);
    end
  endtask

  task automatic test_div32();
    int st, lo;
    exp_t got, e;
    bit ok;
    sel = 0;
    sb.push_back({32'(7 / -2), 1'b0, 4'b0000});
    run_rpn("7 -2", st);
    send(T_OP, OP_DIV);
    lo = 0;
    @(negedge clk);
    tv = 1'b0;
    while (!m_rdy && lo < 100) begin
      lo++;
      @(negedge clk);
    end
    checks++;
    if (lo !== 32) begin
      errors++;
      $display("FAIL div_stall: tok_ready low for %0d cycles, required 32", lo);
    end
    send(T_END, 0);
    get_result(got, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL div_7_m2: got data=%0d ovf=%0b err=%b valid=%0b, required data=%0d ovf=%0b err=%b",
               $signed(got.d), got.o, got.e, ok, $signed(e.d), e.o, e.e);
    end
    sb.push_back({32'(-7 / 2), 1'b0, 4'b0000});
    run_rpn("-7 2 /", st);
    send(T_END, 0);
    get_result(got, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL div_m7_2: got data=%0d ovf=%0b err=%b valid=%0b, required data=%0d ovf=%0b err=%b",
               $signed(got.d), got.o, got.e, ok, $signed(e.d), e.o, e.e);
    end
  endtask

  task automatic test_width8();
    string exprs [3] = '{"100 100 +", "-128 -1 /", "3 4 *"};
    logic signed [7:0] r8 [3];
    logic ov [3] = '{1'b1, 1'b1, 1'b0};
    int st;
    exp_t got, e;
    bit ok;
    r8[0] = 8'(100 + 100);
    r8[1] = 8'sh80;
    r8[2] = 8'(3 * 4);
    sel = 1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back({32'(r8[k]), ov[k], 4'b0000});
      run_rpn(exprs[k], st);
      send(T_END, 0);
      get_result(got, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || got !== e) begin
        errors++;
        $display("FAIL w8_%0d: got data=%0d ovf=%0b err=%b valid=%0b, required data=%0d ovf=%0b err=%b",
                 k, $signed(got.d), got.o, got.e, ok, $signed(e.d), e.o, e.e);
      end
    end
    sel = 0;
  endtask

  task automatic test_errors();
    string exprs [4] = '{"3 +", "5 0 /", "1 2", "1 2 3 4 5"};
    int    sels  [4] = '{0, 0, 0, 2};
    logic [3:0] errs [4] = '{4'b0001, 4'b0100, 4'b1000, 4'b0010};
    int st;
    exp_t got, e;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      sel = sels[k];
      sb.push_back({32'd0, 1'b0, errs[k]});
      run_rpn(exprs[k], st);
      send(T_END, 0);
      get_result(got, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || got !== e) begin
        errors++;
        $display("FAIL err_%0d: got data=%0d ovf=%0b err=%b valid=%0b, required data=%0d ovf=%0b err=%b",
                 k, $signed(got.d), got.o, got.e, ok, $signed(e.d), e.o, e.e);
      end
      sb.push_back({32'(1 + 1), 1'b0, 4'b0000});
      run_rpn("1 1 +", st);
      send(T_END, 0);
      get_result(got, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || got !== e) begin
        errors++;
        $display("FAIL err_recover_%0d: got data=%0d ovf=%0b err=%b valid=%0b, required data=%0d ovf=%0b err=%b",
                 k, $signed(got.d), got.o, got.e, ok, $signed(e.d), e.o, e.e);
      end
    end
    sel = 0;
  endtask

  task automatic test_hold();
    int st;
    exp_t got, e;
    bit ok;
    sel = 0;
    sb.push_back({32'(2 + 3), 1'b0, 4'b0000});
    run_rpn("2 3 +", st);
    send(T_END, 0);
    @(negedge clk);
    tv = 1'b1; tt = T_OPND; td = 32'd99; rr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({m_vld, m_rdy, m_dat, m_ovf, m_err} !== {1'b1, 1'b0, sb[0]}) begin
        errors++;
        $display("FAIL hold_c%0d: vld=%0b rdy=%0b data=%0d ovf=%0b err=%b, required vld=1 rdy=0 data=%0d ovf=%0b err=%b",
                 c, m_vld, m_rdy, $signed(m_dat), m_ovf, m_err, $signed(sb[0].d), sb[0].o, sb[0].e);
      end
      @(negedge clk);
    end
    get_result(got, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL hold_result: got data=%0d ovf=%0b err=%b valid=%0b, required data=%0d ovf=%0b err=%b",
               $signed(got.d), got.o, got.e, ok, $signed(e.d), e.o, e.e);
    end
  endtask

  task automatic test_back_to_back();
    int st;
    exp_t e;
    sel = 0;
    @(negedge clk);
    rr = 1'b1;
    sb.push_back({32'(4 * 5), 1'b0, 4'b0000});
    run_rpn("4 5 *", st);
    send(T_END, 0);
    @(negedge clk);
    tv = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({m_vld, m_dat, m_ovf, m_err} !== {1'b1, e}) begin
      errors++;
      $display("FAIL b2b_result: vld=%0b data=%0d ovf=%0b err=%b, required vld=1 data=%0d ovf=%0b err=%b",
               m_vld, $signed(m_dat), m_ovf, m_err, $signed(e.d), e.o, e.e);
    end
    @(negedge clk);
    checks++;
    if ({m_rdy, m_vld} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_ready: rdy=%0b vld=%0b, required rdy=1 vld=0", m_rdy, m_vld);
    end
    rr = 1'b0;
  endtask

  task automatic test_reset_in_div();
    int st;
    exp_t got, e;
    bit ok;
    sel = 0;
    run_rpn("100 7", st);
    send(T_OP, OP_DIV);
    @(negedge clk);
    tv = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_rdy, m_vld, m_dat, m_ovf, m_err} !== 38'b0) begin
      errors++;
      $display("FAIL div_abort_outputs: rdy=%0b vld=%0b data=%h ovf=%0b err=%b, required all 0",
               m_rdy, m_vld, m_dat, m_ovf, m_err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (m_rdy !== 1'b1) begin
      errors++;
      $display("FAIL div_abort_ready: got %0b required 1", m_rdy);
    end
    sb.push_back({32'(2 + 3), 1'b0, 4'b0000});
    run_rpn("2 3 +", st);
    send(T_END, 0);
    get_result(got, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL div_abort_after: got data=%0d ovf=%0b err=%b valid=%0b, required data=%0d ovf=%0b err=%b",
               $signed(got.d), got.o, got.e, ok, $signed(e.d), e.o, e.e);
    end
  endtask

  initial begin
    test_reset();
    test_expr_521();
    test_div32();
    test_width8();
    test_errors();
    test_hold();
    test_back_to_back();
    test_reset_in_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
